// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/debounce.sv
// Push-button debouncer: synchronizes PB, follows it only after STABLE_CYCLES
// consecutive clocks of a changed level, and emits one-cycle rise/fall strobes.
module debounce #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic PB,
    output logic PB_debounced,
    output logic PB_rise,
    output logic PB_fall
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          s2;
    logic [CW-1:0] cnt;

    sync_2ff u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (PB),
        .q     (s2)
    );

    // Any cycle where s2 agrees with the output discards partial progress.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt          <= '0;
            PB_debounced <= 1'b0;
            PB_rise      <= 1'b0;
            PB_fall      <= 1'b0;
        end else begin
            PB_rise <= 1'b0;
            PB_fall <= 1'b0;
            if (s2 == PB_debounced) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                PB_debounced <= s2;
                cnt          <= '0;
                PB_rise      <= s2;
                PB_fall      <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce with STABLE_CYCLES=16; expected latencies are hand-derived (18 clocks).
`timescale 1ns/100ps
module tb_debounce;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic PB = 1'b0;
    logic PB_debounced, PB_rise, PB_fall;

    int total = 0;
    int passed = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int both_cnt = 0;

    debounce #(.STABLE_CYCLES(16)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .PB           (PB),
        .PB_debounced (PB_debounced),
        .PB_rise      (PB_rise),
        .PB_fall      (PB_fall)
    );

    always #1 CLK = ~CLK;

    // Advance one clock and sample half a nanosecond after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #0.5;
            if (PB_rise) rise_cnt++;
            if (PB_fall) fall_cnt++;
            if (PB_rise && PB_fall) both_cnt++;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clr_counts();
        rise_cnt = 0;
        fall_cnt = 0;
    endtask

    initial begin
        int elapsed;
        int iv;

        // Reset and idle
        RST_N = 1'b0;
        PB = 1'b0;
        tick(5);
        chk("rst_deb", PB_debounced, 0);
        chk("rst_rise", PB_rise, 0);
        chk("rst_fall", PB_fall, 0);
        RST_N = 1'b1;
        tick(100);
        chk("idle_deb", PB_debounced, 0);
        chk("idle_strobes", rise_cnt + fall_cnt, 0);

        // Clean press: output follows at edge 18 after the change
        clr_counts();
        PB = 1'b1;
        tick(17);
        chk("press_e17_deb", PB_debounced, 0);
        tick();
        chk("press_e18_deb", PB_debounced, 1);
        chk("press_e18_rise", PB_rise, 1);
        tick();
        chk("press_e19_rise", PB_rise, 0);
        tick(381);
        chk("press_hold_deb", PB_debounced, 1);
        chk("press_rise_cnt", rise_cnt, 1);
        chk("press_fall_cnt", fall_cnt, 0);

        // Clean release, then press again
        clr_counts();
        PB = 1'b0;
        tick(17);
        chk("rel_e17_deb", PB_debounced, 1);
        tick();
        chk("rel_e18_deb", PB_debounced, 0);
        chk("rel_e18_fall", PB_fall, 1);
        tick();
        chk("rel_e19_fall", PB_fall, 0);
        tick(81);
        chk("rel_fall_cnt", fall_cnt, 1);
        chk("rel_rise_cnt", rise_cnt, 0);
        PB = 1'b1;
        tick(17);
        chk("repress_e17_deb", PB_debounced, 0);
        tick();
        chk("repress_e18_deb", PB_debounced, 1);
        tick(30);
        PB = 1'b0;
        tick(40);
        chk("pre_bounce_deb", PB_debounced, 0);

        // Bounce: short random intervals, then the final toggle to 1
        clr_counts();
        elapsed = 0;
        while (elapsed < 200) begin
            iv = $urandom_range(10, 3);
            PB = ~PB;
            tick(iv);
            elapsed += iv;
        end
        if (PB) begin
            PB = 1'b0;
            tick(3);
        end
        chk("bounce_no_change", rise_cnt + fall_cnt, 0);
        PB = 1'b1;
        tick(17);
        chk("bounce_e17_deb", PB_debounced, 0);
        tick();
        chk("bounce_e18_deb", PB_debounced, 1);
        tick(30);
        chk("bounce_rise_cnt", rise_cnt, 1);
        chk("bounce_fall_cnt", fall_cnt, 0);

        // Glitch rejection: 15-clock pulse rejected, 16-clock pulse accepted
        PB = 1'b0;
        tick(40);
        clr_counts();
        PB = 1'b1;
        tick(15);
        PB = 1'b0;
        tick(40);
        chk("glitch15_deb", PB_debounced, 0);
        chk("glitch15_strobes", rise_cnt + fall_cnt, 0);
        PB = 1'b1;
        tick(16);
        PB = 1'b0;
        tick(2);
        chk("glitch16_deb", PB_debounced, 1);
        chk("glitch16_rise", PB_rise, 1);
        tick(15);
        chk("glitch16_fall_e17", PB_debounced, 1);
        tick();
        chk("glitch16_fall_e18", PB_debounced, 0);
        chk("glitch16_fall", PB_fall, 1);
        tick(20);

        // Async reset 10 clocks into a press
        clr_counts();
        PB = 1'b1;
        tick(10);
        RST_N = 1'b0;
        #0.2;
        chk("amid_deb", PB_debounced, 0);
        chk("amid_rise", PB_rise, 0);
        #0.8;
        RST_N = 1'b1;
        tick(17);
        chk("arel_e17_deb", PB_debounced, 0);
        tick();
        chk("arel_e18_deb", PB_debounced, 1);
        tick(5);
        // Reset while output is high drops it before any clock edge
        RST_N = 1'b0;
        #0.2;
        chk("ahigh_deb", PB_debounced, 0);
        #0.8;
        RST_N = 1'b1;
        tick(5);

        chk("never_both", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
